// File: rtl/jpeg_bit_unpacker_pkg.sv
`default_nettype none
// ============================================================================
// Package  : jpeg_dec_pkg
// Purpose  : Shared types and constants for the JPEG decode-path bit unpacker:
//            unpacker state encoding, JPEG marker codes, buffer widths.
// Revision : 1.0 - initial release
// ============================================================================
package jpeg_dec_pkg;

  // Bit-buffer width; must hold a full peek window plus two appended bytes.
  localparam int BUF_W  = 32;
  // Peek window width: longest Huffman code plus magnitude lookahead.
  localparam int PEEK_W = 16;

  // Byte-stream parser state.
  typedef enum logic [1:0] {
    NORMAL  = 2'd0,
    FF_SEEN = 2'd1,
    MARKER  = 2'd2
  } unpack_state_t;

  // Marker codes (second byte following 0xFF).
  localparam logic [7:0] M_SOI  = 8'hD8;
  localparam logic [7:0] M_EOI  = 8'hD9;
  localparam logic [7:0] M_RST0 = 8'hD0;
  localparam logic [7:0] M_RST1 = 8'hD1;
  localparam logic [7:0] M_RST2 = 8'hD2;
  localparam logic [7:0] M_RST3 = 8'hD3;
  localparam logic [7:0] M_RST4 = 8'hD4;
  localparam logic [7:0] M_RST5 = 8'hD5;
  localparam logic [7:0] M_RST6 = 8'hD6;
  localparam logic [7:0] M_RST7 = 8'hD7;
  localparam logic [7:0] M_DHT  = 8'hC4;
  localparam logic [7:0] M_DQT  = 8'hDB;
  localparam logic [7:0] M_SOS  = 8'hDA;

  // True for any restart marker RST0..RST7.
  function automatic logic is_rst_marker(input logic [7:0] code);
    return (code[7:3] == 5'b11010);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jpeg_bit_unpacker_shifter.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_bit_shifter
// Purpose  : Combinational buffer update: left-shift the MSB-aligned bit
//            buffer (zero fill) and optionally OR a byte in at a bit
//            position measured from the MSB.
// Revision : 1.0 - initial release
// ============================================================================
module jpeg_bit_shifter
  import jpeg_dec_pkg::*;
(
  input  logic [BUF_W-1:0] buf_in,
  input  logic [4:0]       shift_amt,
  input  logic             ins_en,
  input  logic [7:0]       ins_byte,
  input  logic [5:0]       ins_pos,
  output logic [BUF_W-1:0] buf_out
);

  logic [BUF_W-1:0] shifted;
  logic [BUF_W-1:0] placed;

  // Positions at and beyond ins_pos are zero after the shift, so OR-ing the
  // byte in is equivalent to writing it.
  always_comb begin
    shifted = buf_in << shift_amt;
    placed  = {ins_byte, {(BUF_W-8){1'b0}}} >> ins_pos;
    buf_out = ins_en ? (shifted | placed) : shifted;
  end

endmodule
`default_nettype wire

// File: rtl/jpeg_bit_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : jpeg_bit_unpacker
// Purpose  : Entropy-coded-segment front end. Accepts compressed bytes,
//            strips 0xFF00 stuffing and 0xFF fill, stops on markers, and
//            presents a 16-bit MSB-aligned peek window to a Huffman decoder
//            that consumes 0..16 bits per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module jpeg_bit_unpacker
  import jpeg_dec_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic [PEEK_W-1:0] peek_data,
  output logic [5:0]        bit_count,
  input  logic              consume_en,
  input  logic [4:0]        consume_len,
  input  logic              align_en,
  output logic              marker_found,
  output logic [7:0]        marker_code,
  input  logic              marker_clear,
  input  logic              flush,
  output logic              underflow_err
);

  unpack_state_t    state;
  logic [BUF_W-1:0] bit_buf;
  logic [BUF_W-1:0] next_buf;
  logic [4:0]       shift_amt;
  logic             underflow_req;
  logic             accept;
  logic             do_append;
  logic [7:0]       append_byte;
  logic [5:0]       base_count;
  logic [5:0]       next_count;

  // Registered bit_count caps occupancy at 24 before a byte is taken, so the
  // buffer can never overflow regardless of what is consumed this cycle.
  assign byte_ready = !flush && (state != MARKER) && (bit_count <= 6'd24);
  assign accept     = byte_valid && byte_ready;
  assign peek_data  = bit_buf[BUF_W-1 -: PEEK_W];

  // Shift selection: align overrides consume; oversize consume is rejected.
  always_comb begin
    shift_amt     = 5'd0;
    underflow_req = 1'b0;
    if (align_en) begin
      shift_amt = {2'b00, bit_count[2:0]};
    end else if (consume_en) begin
      if ({1'b0, consume_len} <= bit_count) begin
        shift_amt = consume_len;
      end else begin
        underflow_req = 1'b1;
      end
    end
  end

  // Destuffing decision: only data bytes and the 0xFF of an 0xFF00 pair land
  // in the buffer; the append goes in after this cycle's shift.
  always_comb begin
    do_append   = accept &&
                  (((state == NORMAL)  && (byte_data != 8'hFF)) ||
                   ((state == FF_SEEN) && (byte_data == 8'h00)));
    append_byte = (state == FF_SEEN) ? 8'hFF : byte_data;
    base_count  = bit_count - {1'b0, shift_amt};
    next_count  = base_count + (do_append ? 6'd8 : 6'd0);
  end

  jpeg_bit_shifter u_shifter (
    .buf_in    (bit_buf),
    .shift_amt (shift_amt),
    .ins_en    (do_append),
    .ins_byte  (append_byte),
    .ins_pos   (base_count),
    .buf_out   (next_buf)
  );

  // Parser FSM, buffer, counters and flags; flush outranks everything.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= NORMAL;
      bit_buf       <= '0;
      bit_count     <= 6'd0;
      marker_found  <= 1'b0;
      marker_code   <= 8'h00;
      underflow_err <= 1'b0;
    end else if (flush) begin
      state         <= NORMAL;
      bit_buf       <= '0;
      bit_count     <= 6'd0;
      marker_found  <= 1'b0;
      marker_code   <= 8'h00;
      underflow_err <= 1'b0;
    end else begin
      bit_buf   <= next_buf;
      bit_count <= next_count;
      if (underflow_req) begin
        underflow_err <= 1'b1;
      end
      case (state)
        NORMAL: begin
          if (accept && (byte_data == 8'hFF)) begin
            state <= FF_SEEN;
          end
        end
        FF_SEEN: begin
          if (accept) begin
            if (byte_data == 8'h00) begin
              state <= NORMAL;
            end else if (byte_data != 8'hFF) begin
              marker_code  <= byte_data;
              marker_found <= 1'b1;
              state        <= MARKER;
            end
          end
        end
        MARKER: begin
          if (marker_clear) begin
            marker_found <= 1'b0;
            state        <= NORMAL;
          end
        end
        default: state <= NORMAL;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_jpeg_bit_unpacker.sv
`default_nettype none
// ============================================================================
// Module   : tb_jpeg_bit_unpacker
// Purpose  : Directed, table-driven self-checking bench for jpeg_bit_unpacker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jpeg_bit_unpacker;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [15:0] peek_data;
  logic [5:0]  bit_count;
  logic        consume_en;
  logic [4:0]  consume_len;
  logic        align_en;
  logic        marker_found;
  logic [7:0]  marker_code;
  logic        marker_clear;
  logic        flush;
  logic        underflow_err;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  jpeg_bit_unpacker dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_ready    (byte_ready),
    .peek_data     (peek_data),
    .bit_count     (bit_count),
    .consume_en    (consume_en),
    .consume_len   (consume_len),
    .align_en      (align_en),
    .marker_found  (marker_found),
    .marker_code   (marker_code),
    .marker_clear  (marker_clear),
    .flush         (flush),
    .underflow_err (underflow_err)
  );

  typedef struct {
    logic        bv;
    logic [7:0]  bd;
    logic        ce;
    logic [4:0]  cl;
    logic        ae;
    logic        mclr;
    logic        fl;
    logic        rdy;    // byte_ready during the cycle
    logic [15:0] peek;   // registered outputs after the edge
    logic [5:0]  cnt;
    logic        mf;
    logic [7:0]  mcode;
    logic        uf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic bv, logic [7:0] bd, logic ce, logic [4:0] cl,
                              logic ae, logic mclr, logic fl, logic rdy,
                              logic [15:0] peek, logic [5:0] cnt, logic mf,
                              logic [7:0] mcode, logic uf);
    vec_t v;
    v.bv = bv; v.bd = bd; v.ce = ce; v.cl = cl; v.ae = ae; v.mclr = mclr;
    v.fl = fl; v.rdy = rdy; v.peek = peek; v.cnt = cnt; v.mf = mf;
    v.mcode = mcode; v.uf = uf;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h required=%0h", name, idx, act, exp);
    end
  endtask

  task automatic idle_inputs();
    byte_valid = 1'b0; byte_data = 8'h00; consume_en = 1'b0; consume_len = 5'd0;
    align_en = 1'b0; marker_clear = 1'b0; flush = 1'b0;
  endtask

  task automatic chk_regs(input int idx, input logic [15:0] peek, input logic [5:0] cnt,
                          input logic mf, input logic [7:0] mcode, input logic uf);
    chk("peek_data",     idx, 32'(peek_data),     32'(peek));
    chk("bit_count",     idx, 32'(bit_count),     32'(cnt));
    chk("marker_found",  idx, 32'(marker_found),  32'(mf));
    chk("marker_code",   idx, 32'(marker_code),   32'(mcode));
    chk("underflow_err", idx, 32'(underflow_err), 32'(uf));
  endtask

  initial begin
    //                 bv  bd    ce cl  ae mc fl  rdy peek     cnt mf code   uf
    // Two plain bytes
    vecs.push_back(mk(1, 8'hA5, 0, 0, 0, 0, 0, 1, 16'hA500, 8,  0, 8'h00, 0)); // 0
    vecs.push_back(mk(1, 8'h3C, 0, 0, 0, 0, 0, 1, 16'hA53C, 16, 0, 8'h00, 0)); // 1
    // Stuffed 0xFF00
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 16'h0000, 0,  0, 8'h00, 0)); // 2
    vecs.push_back(mk(1, 8'h12, 0, 0, 0, 0, 0, 1, 16'h1200, 8,  0, 8'h00, 0)); // 3
    vecs.push_back(mk(1, 8'hFF, 0, 0, 0, 0, 0, 1, 16'h1200, 8,  0, 8'h00, 0)); // 4
    vecs.push_back(mk(1, 8'h00, 0, 0, 0, 0, 0, 1, 16'h12FF, 16, 0, 8'h00, 0)); // 5
    vecs.push_back(mk(1, 8'h34, 0, 0, 0, 0, 0, 1, 16'h12FF, 24, 0, 8'h00, 0)); // 6
    vecs.push_back(mk(0, 8'h00, 1, 8, 0, 0, 0, 1, 16'hFF34, 16, 0, 8'h00, 0)); // 7
    // Fill byte then EOI marker
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 16'h0000, 0,  0, 8'h00, 0)); // 8
    vecs.push_back(mk(1, 8'hFF, 0, 0, 0, 0, 0, 1, 16'h0000, 0,  0, 8'h00, 0)); // 9
    vecs.push_back(mk(1, 8'hFF, 0, 0, 0, 0, 0, 1, 16'h0000, 0,  0, 8'h00, 0)); // 10
    vecs.push_back(mk(1, 8'hD9, 0, 0, 0, 0, 0, 1, 16'h0000, 0,  1, 8'hD9, 0)); // 11
    vecs.push_back(mk(1, 8'h77, 0, 0, 0, 0, 0, 0, 16'h0000, 0,  1, 8'hD9, 0)); // 12
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 16'h0000, 0,  0, 8'hD9, 0)); // 13
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 16'h0000, 0,  0, 8'hD9, 0)); // 14
    // Fill to 32 bits, consume with a stalled byte, then refill
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 16'h0000, 0,  0, 8'h00, 0)); // 15
    vecs.push_back(mk(1, 8'h11, 0, 0, 0, 0, 0, 1, 16'h1100, 8,  0, 8'h00, 0)); // 16
    vecs.push_back(mk(1, 8'h22, 0, 0, 0, 0, 0, 1, 16'h1122, 16, 0, 8'h00, 0)); // 17
    vecs.push_back(mk(1, 8'h33, 0, 0, 0, 0, 0, 1, 16'h1122, 24, 0, 8'h00, 0)); // 18
    vecs.push_back(mk(1, 8'h44, 0, 0, 0, 0, 0, 1, 16'h1122, 32, 0, 8'h00, 0)); // 19
    vecs.push_back(mk(1, 8'h55, 1, 8, 0, 0, 0, 0, 16'h2233, 24, 0, 8'h00, 0)); // 20
    vecs.push_back(mk(1, 8'h55, 0, 0, 0, 0, 0, 1, 16'h2233, 32, 0, 8'h00, 0)); // 21
    vecs.push_back(mk(0, 8'h00, 1, 16,0, 0, 0, 0, 16'h4455, 16, 0, 8'h00, 0)); // 22
    // Underflow and flush
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 16'h0000, 0,  0, 8'h00, 0)); // 23
    vecs.push_back(mk(1, 8'hA8, 0, 0, 0, 0, 0, 1, 16'hA800, 8,  0, 8'h00, 0)); // 24
    vecs.push_back(mk(0, 8'h00, 1, 3, 0, 0, 0, 1, 16'h4000, 5,  0, 8'h00, 0)); // 25
    vecs.push_back(mk(0, 8'h00, 1, 7, 0, 0, 0, 1, 16'h4000, 5,  0, 8'h00, 1)); // 26
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 0, 1, 16'h4000, 5,  0, 8'h00, 1)); // 27
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 0, 1, 0, 16'h0000, 0,  0, 8'h00, 0)); // 28
    // Align beats consume; shift plus append in one cycle
    vecs.push_back(mk(1, 8'hB6, 0, 0, 0, 0, 0, 1, 16'hB600, 8,  0, 8'h00, 0)); // 29
    vecs.push_back(mk(1, 8'h7D, 0, 0, 0, 0, 0, 1, 16'hB67D, 16, 0, 8'h00, 0)); // 30
    vecs.push_back(mk(0, 8'h00, 1, 3, 0, 0, 0, 1, 16'hB3E8, 13, 0, 8'h00, 0)); // 31
    vecs.push_back(mk(0, 8'h00, 1, 3, 1, 0, 0, 1, 16'h7D00, 8,  0, 8'h00, 0)); // 32
    vecs.push_back(mk(1, 8'h9C, 1, 4, 0, 0, 0, 1, 16'hD9C0, 12, 0, 8'h00, 0)); // 33
    // Marker with bits still buffered; consume while stalled
    vecs.push_back(mk(1, 8'hFF, 0, 0, 0, 0, 0, 1, 16'hD9C0, 12, 0, 8'h00, 0)); // 34
    vecs.push_back(mk(1, 8'hC4, 0, 0, 0, 0, 0, 1, 16'hD9C0, 12, 1, 8'hC4, 0)); // 35
    vecs.push_back(mk(1, 8'h11, 1, 4, 0, 0, 0, 0, 16'h9C00, 8,  1, 8'hC4, 0)); // 36
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 1, 0, 0, 16'h9C00, 8,  0, 8'hC4, 0)); // 37

    // Reset state
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_peek",  -1, 32'(peek_data),     32'h0);
    chk("reset_count", -1, 32'(bit_count),     32'h0);
    chk("reset_mf",    -1, 32'(marker_found),  32'h0);
    chk("reset_code",  -1, 32'(marker_code),   32'h0);
    chk("reset_uf",    -1, 32'(underflow_err), 32'h0);
    chk("reset_ready", -1, 32'(byte_ready),    32'h1);
    @(negedge clock);
    reset_n = 1'b1;

    // Table-driven steps: drive at negedge, check ready, check regs after edge
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      byte_valid = vecs[i].bv; byte_data = vecs[i].bd;
      consume_en = vecs[i].ce; consume_len = vecs[i].cl;
      align_en = vecs[i].ae; marker_clear = vecs[i].mclr; flush = vecs[i].fl;
      #1;
      chk("byte_ready", i, 32'(byte_ready), 32'(vecs[i].rdy));
      @(posedge clock);
      #1;
      chk_regs(i, vecs[i].peek, vecs[i].cnt, vecs[i].mf, vecs[i].mcode, vecs[i].uf);
    end

    // Reset while half-way through an 0xFF pair: the pending 0xFF is lost
    @(negedge clock);
    idle_inputs();
    flush = 1'b1;
    @(negedge clock);
    idle_inputs();
    byte_valid = 1'b1; byte_data = 8'h5A;
    @(negedge clock);
    byte_data = 8'hFF;
    @(posedge clock);
    #1;
    chk_regs(100, 16'h5A00, 6'd8, 1'b0, 8'h00, 1'b0);
    #2;
    reset_n = 1'b0;
    byte_valid = 1'b0;
    #1;
    chk_regs(101, 16'h0000, 6'd0, 1'b0, 8'h00, 1'b0);
    chk("byte_ready", 101, 32'(byte_ready), 32'h1);
    @(negedge clock);
    reset_n = 1'b1;
    byte_valid = 1'b1; byte_data = 8'h00;
    @(posedge clock);
    #1;
    chk_regs(102, 16'h0000, 6'd8, 1'b0, 8'h00, 1'b0);
    @(negedge clock);
    idle_inputs();
    @(posedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
